rf_wb_arbiter: RTL
==================

Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port among N_REQ write-back sources (e.g. ALU, load unit, mul/div), using round-robin valid/ready arbitration.
- One registered stage sits between the winning request and the RF write port.
- That stage's contents are exported as a forwarding tap so decode can bypass the in-flight value.
- Sits between the execute/memory units and the RF write inputs (write_e, rd, write_d).

Parameters:
- N_REQ, 3, number of write-back requesters (2..8).
- XLEN, 32, data width.
- REG_AW, 5, register address width (32 registers).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  per-requester write-back request.
- req_rd  in  N_REQ*REG_AW  packed destination register, requester i at bits [i*REG_AW +: REG_AW].
- req_data  in  N_REQ*XLEN  packed write data, requester i at bits [i*XLEN +: XLEN].
- req_ready  out  N_REQ  one-hot grant; request accepted on a cycle where valid&ready.
- wb_write_e  out  1  RF write enable (registered).
- wb_rd  out  REG_AW  RF write address (registered).
- wb_write_d  out  XLEN  RF write data (registered).
- fwd_valid  out  1  equals wb_write_e; a value is in flight to the RF.
- fwd_rd  out  REG_AW  equals wb_rd.
- fwd_data  out  XLEN  equals wb_write_d.

Behaviour:
- Reset (async, rst_n low): wb_write_e=0, wb_rd=0, wb_write_d=0, round-robin pointer rr_ptr=0. req_ready is combinational and reads 0 while in reset.
- Arbitration (combinational, each cycle):
  - Search starts at index rr_ptr and proceeds rr_ptr+1, ... wrapping modulo N_REQ.
  - The first requester with req_valid=1 gets req_ready=1; all others get 0.
  - At most one ready bit is ever high.
  - No valid requests gives req_ready all zeros.
- The RF write port never stalls, so a granted request is always accepted the same cycle. There is no backpressure beyond losing arbitration.
- Requester rule: once req_valid is asserted, the requester must hold valid, rd and data stable until it sees ready. The arbiter does not check this.
- Pointer update on the clock edge:
  - On a grant to index g, rr_ptr becomes (g+1) mod N_REQ.
  - With no grant, rr_ptr holds.
- Output stage on the clock edge after an accept:
  - wb_rd and wb_write_d load the granted rd and data.
  - wb_write_e is set to (granted rd != 0).
  - With no accept, wb_write_e=0 and wb_rd/wb_write_d hold their previous values.
- Latency: 1 cycle from accept to wb_write_e high. The RF stores the value at the next edge, so it is readable 2 edges after accept; fwd_* covers the gap.
- x0 rule: a request with rd=0 is still granted and consumed (ready=1, pointer advances), but it never raises wb_write_e or fwd_valid.
- Same rd from two requesters on consecutive cycles: both are written in arbitration order, and the later grant wins in the RF. No merging.
- A single continuously valid requester is granted every cycle, giving 1 write per cycle.
- With all N_REQ valid, grants rotate, so each requester waits at most N_REQ-1 cycles.
- Reset asserted mid-operation: an in-flight write is dropped (wb_write_e forced to 0 immediately) and the pointer returns to 0. Requesters must re-present after reset.

Optional Feature:
- Macro WB_STATS_EN.
- Defined, additional outputs:
  - stat_grants, N_REQ*16 bits: per-requester count of accepted requests.
  - stat_conflicts, 16 bits: count of cycles with 2 or more req_valid bits set.
- Counter behaviour when defined:
  - All counters saturate at 16'hFFFF.
  - All counters clear on reset.
  - Additional input stat_clr (1 bit) synchronously zeroes every counter. On a same-cycle clear and increment, the clear wins.
- Not defined: none of these ports or registers exist, and arbitration and timing are identical.

Test Plan:
- Reset: hold rst_n=0 with all req_valid=1 -> req_ready=000, wb_write_e=0; release -> first grant goes to req 0 (rr_ptr=0).
- Single requester: req1 valid with rd=5, data=32'hDEADBEEF for 1 cycle -> ready[1]=1 that cycle; next cycle wb_write_e=1, wb_rd=5, wb_write_d=DEADBEEF, fwd_* match; cycle after that wb_write_e=0.
- Round-robin: all 3 valid continuously for 6 cycles with rd=1,2,3 -> grant order 0,1,2,0,1,2, with wb_rd sequence 1,2,3,1,2,3 one cycle later.
- x0 suppression: req2 valid with rd=0, data=32'h12345678 -> ready[2]=1 and rr_ptr becomes 0; next cycle wb_write_e=0 and fwd_valid=0.
- Async reset mid-flight: accept a write to rd=7, then drop rst_n before the next edge -> wb_write_e falls to 0 without waiting for a clock edge; after release the next grant goes to the lowest valid index.
- WB_STATS_EN: 10 cycles with req0 and req1 both valid -> stat_grants[0]=5, [1]=5, [2]=0, stat_conflicts=10; pulse stat_clr -> all counters read 0 the next cycle.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port among N_REQ write-back sources.
// One registered stage drives the RF and doubles as a forwarding tap; define WB_STATS_EN for grant/conflict counters.
module rf_wb_arbiter #(
  parameter int N_REQ  = 3,
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*REG_AW-1:0]  req_rd,
  input  logic [N_REQ*XLEN-1:0]    req_data,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     wb_write_e,
  output logic [REG_AW-1:0]        wb_rd,
  output logic [XLEN-1:0]          wb_write_d,
  output logic                     fwd_valid,
  output logic [REG_AW-1:0]        fwd_rd,
  output logic [XLEN-1:0]          fwd_data
`ifdef WB_STATS_EN
  ,
  input  logic                     stat_clr,
  output logic [N_REQ*16-1:0]      stat_grants,
  output logic [15:0]              stat_conflicts
`endif
);

  localparam int                PTR_W = $clog2(N_REQ);
  localparam logic [PTR_W:0]    N_L   = (PTR_W+1)'(N_REQ);
  localparam logic [PTR_W-1:0]  LAST  = PTR_W'(N_REQ-1);

  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  gnt_idx;
  logic [PTR_W-1:0]  nxt_ptr;
  logic [N_REQ-1:0]  rot;
  logic [PTR_W:0]    off;
  logic [PTR_W:0]    sum;
  logic              found;
  logic [N_REQ-1:0]  grant;
  logic [REG_AW-1:0] sel_rd;
  logic [XLEN-1:0]   sel_data;

  logic              vld_p1;
  logic [REG_AW-1:0] rd_p1;
  logic [XLEN-1:0]   data_p1;

  // Stage p0: rotate requests so rr_ptr sits at bit 0, take the lowest set bit, map back.
  always_comb begin
    rot   = N_REQ'({req_valid, req_valid} >> rr_ptr);
    found = |rot;
    off   = '0;
    for (int k = N_REQ-1; k >= 0; k--) begin
      if (rot[k]) off = (PTR_W+1)'(k);
    end
    sum = {1'b0, rr_ptr} + off;
    if (sum >= N_L) sum = sum - N_L;
    gnt_idx = sum[PTR_W-1:0];
    nxt_ptr = (gnt_idx == LAST) ? '0 : gnt_idx + PTR_W'(1);
    grant    = '0;
    sel_rd   = '0;
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (found && (gnt_idx == PTR_W'(i))) begin
        grant[i] = 1'b1;
        sel_rd   = req_rd[i*REG_AW +: REG_AW];
        sel_data = req_data[i*XLEN +: XLEN];
      end
    end
  end

  assign req_ready = rst_n ? grant : '0;

  // Stage p1: registered RF write; rd == x0 is consumed but never raises the enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr  <= '0;
      vld_p1  <= 1'b0;
      rd_p1   <= '0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= found && (sel_rd != '0);
      if (found) begin
        rr_ptr  <= nxt_ptr;
        rd_p1   <= sel_rd;
        data_p1 <= sel_data;
      end
    end
  end

  assign wb_write_e = vld_p1;
  assign wb_rd      = rd_p1;
  assign wb_write_d = data_p1;
  assign fwd_valid  = vld_p1;
  assign fwd_rd     = rd_p1;
  assign fwd_data   = data_p1;

`ifdef WB_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  logic [15:0] grant_cnt [N_REQ];
  logic [15:0] conflict_cnt;
  logic        multi_vld;

  // Clearing the lowest set bit leaves something only when two or more are set.
  assign multi_vld = |(req_valid & (req_valid - N_REQ'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REQ; i++) grant_cnt[i] <= '0;
      conflict_cnt <= '0;
    end else if (stat_clr) begin
      for (int i = 0; i < N_REQ; i++) grant_cnt[i] <= '0;
      conflict_cnt <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (grant[i]) grant_cnt[i] <= sat_inc(grant_cnt[i]);
      end
      if (multi_vld) conflict_cnt <= sat_inc(conflict_cnt);
    end
  end

  for (genvar g = 0; g < N_REQ; g++) begin : g_stat
    assign stat_grants[g*16 +: 16] = grant_cnt[g];
  end
  assign stat_conflicts = conflict_cnt;
`endif

endmodule
